// File: rtl/frame_crop_sequencer.sv
// -----------------------------------------------------------------------------
// frame_crop_sequencer
//
// Purpose:
//   Sequencer for a single-port frame store of SRC_W x SRC_H bytes. One frame
//   cycle is a full-frame fill from the incoming pixel stream followed by a
//   raster readout of a CROP_W x CROP_H window whose top-left corner sits at
//   (CROP_X, CROP_Y) in the source frame.
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   reset_i       synchronous, active-high reset
//   start_i       begin a frame cycle (only honoured in IDLE)
//   px_valid_i    source pixel present this cycle
//   px_ready_o    pixel accepted (high throughout FILL)
//   wr_inc_o      store write strobe (px_valid_i & px_ready_o)
//   wr_addr_o     store write address of the pixel accepted this cycle
//   out_ready_i   downstream can take a crop pixel this cycle
//   rd_en_o       store read / crop output strobe (out_ready_i during READ)
//   rd_addr_o     source address of the crop pixel being read
//   out_idx_o     raster index of that pixel inside the crop window
//   busy_o        high in FILL, READ and DONE
//   overrun_o     (optional) sticky flag: pixel offered during READ or DONE
//   frame_done_o  one-cycle pulse after the last crop strobe
//
// Configuration:
//   FRAME_SEQ_OVERRUN_EN  when defined, adds the overrun_o output. Without it
//                         pixels offered outside FILL are silently dropped.
// -----------------------------------------------------------------------------
module frame_crop_sequencer #(
    parameter int SRC_W  = 330,
    parameter int SRC_H  = 110,
    parameter int CROP_W = 300,
    parameter int CROP_H = 100,
    parameter int CROP_X = 30,
    parameter int CROP_Y = 10,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              px_valid_i,
    output logic              px_ready_o,
    output logic              wr_inc_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    input  logic              out_ready_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic              busy_o,
`ifdef FRAME_SEQ_OVERRUN_EN
    output logic              overrun_o,
`endif
    output logic              frame_done_o
);

    // Window must fit inside the source frame, and the frame inside the
    // address space.
    generate
        if ((CROP_X + CROP_W > SRC_W) || (CROP_Y + CROP_H > SRC_H)) begin : g_bad_window
            $error("frame_crop_sequencer: crop window exceeds source frame");
        end
        if (SRC_W * SRC_H > (2 ** ADDR_W)) begin : g_bad_addr_w
            $error("frame_crop_sequencer: ADDR_W too small for SRC_W*SRC_H");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(SRC_W * SRC_H - 1);
    localparam logic [ADDR_W-1:0] CROP_LAST  = ADDR_W'(CROP_W * CROP_H - 1);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(CROP_W - 1);
    localparam logic [ADDR_W-1:0] RD_BASE    = ADDR_W'(CROP_Y * SRC_W + CROP_X);
    // Jump from the last column of one crop row to the first of the next.
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(SRC_W - CROP_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] out_idx_q;
    logic [ADDR_W-1:0] col_q;
    logic              fill_last;
    logic              read_last;

    assign fill_last = wr_inc_o && (wr_addr_q == FRAME_LAST);
    assign read_last = rd_en_o && (out_idx_q == CROP_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)   state_d = S_FILL;
            S_FILL:  if (fill_last) state_d = S_READ;
            S_READ:  if (read_last) state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Output logic: strobes are purely state-decoded so the store sees the
    // handshake in the same cycle as the source/sink.
    always_comb begin
        px_ready_o   = (state_q == S_FILL);
        wr_inc_o     = (state_q == S_FILL) && px_valid_i;
        rd_en_o      = (state_q == S_READ) && out_ready_i;
        busy_o       = (state_q != S_IDLE);
        frame_done_o = (state_q == S_DONE);
    end

    // Address counters. The last address of each phase is held rather than
    // advanced so the registers show the final address while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            out_idx_q <= '0;
            col_q     <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_i) begin
                wr_addr_q <= '0;
            end else if (wr_inc_o && !fill_last) begin
                wr_addr_q <= wr_addr_q + ONE;
            end

            if (fill_last) begin
                rd_addr_q <= RD_BASE;
                out_idx_q <= '0;
                col_q     <= '0;
            end else if (rd_en_o && !read_last) begin
                out_idx_q <= out_idx_q + ONE;
                if (col_q == COL_LAST) begin
                    col_q     <= '0;
                    rd_addr_q <= rd_addr_q + ROW_STEP;
                end else begin
                    col_q     <= col_q + ONE;
                    rd_addr_q <= rd_addr_q + ONE;
                end
            end
        end
    end

    assign wr_addr_o = wr_addr_q;
    assign rd_addr_o = rd_addr_q;
    assign out_idx_o = out_idx_q;

`ifdef FRAME_SEQ_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            overrun_q <= 1'b0;
        end else if (px_valid_i && ((state_q == S_READ) || (state_q == S_DONE))) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_frame_crop_sequencer.sv
module tb_frame_crop_sequencer;

    localparam int SW = 8;
    localparam int SH = 6;
    localparam int CW = 4;
    localparam int CH = 3;
    localparam int CX = 2;
    localparam int CY = 1;
    localparam int AW = 8;
    localparam int NPIX  = SW * SH;
    localparam int NCROP = CW * CH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i     = 1'b1;
    logic          start_i     = 1'b0;
    logic          px_valid_i  = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          px_ready_o, wr_inc_o, rd_en_o, busy_o, frame_done_o;
    logic [AW-1:0] wr_addr_o, rd_addr_o, out_idx_o;
`ifdef FRAME_SEQ_OVERRUN_EN
    logic          overrun_o;
`endif

    frame_crop_sequencer #(
        .SRC_W(SW), .SRC_H(SH), .CROP_W(CW), .CROP_H(CH),
        .CROP_X(CX), .CROP_Y(CY), .ADDR_W(AW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .px_valid_i   (px_valid_i),
        .px_ready_o   (px_ready_o),
        .wr_inc_o     (wr_inc_o),
        .wr_addr_o    (wr_addr_o),
        .out_ready_i  (out_ready_i),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .out_idx_o    (out_idx_o),
        .busy_o       (busy_o),
`ifdef FRAME_SEQ_OVERRUN_EN
        .overrun_o    (overrun_o),
`endif
        .frame_done_o (frame_done_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Abstract model: phase 0 idle, 1 fill, 2 read, 3 done.
    int m_phase = 0;
    int m_w = 0;          // next pixel number to be written
    int m_r = 0;          // next crop pixel number to be read
    int m_wa_hold = 0;    // last write address issued
    int m_ra_hold = 0;    // last read address issued
    int m_oi_hold = 0;    // last crop index issued
    bit m_ovr = 1'b0;

    int wr_cnt = 0;
    int wr_log[$];
    int rd_log[$];
    int idx_log[$];
    int exp_rd[NCROP] = '{10, 11, 12, 13, 18, 19, 20, 21, 26, 27, 28, 29};

    function automatic int crop_addr(input int k);
        return (CY + k / CW) * SW + CX + (k % CW);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cnt = 0;
        wr_log.delete();
        rd_log.delete();
        idx_log.delete();
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic fill_all();
        px_valid_i = 1'b1;
        repeat (NPIX) step();
        px_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (frame_done_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, int'(frame_done_o), 1);
        step();
        chk({name, "_idle_after_done"}, int'(busy_o), 0);
    endtask

    task automatic check_read_logs(input string name);
        chk({name, "_rd_count"}, rd_log.size(), NCROP);
        for (int i = 0; i < NCROP && i < rd_log.size(); i++) begin
            chk({name, "_rd_addr"}, rd_log[i], exp_rd[i]);
            chk({name, "_out_idx"}, idx_log[i], i);
        end
    endtask

    task automatic model_update();
        if (reset_i) begin
            m_phase = 0; m_w = 0; m_r = 0;
            m_wa_hold = 0; m_ra_hold = 0; m_oi_hold = 0; m_ovr = 1'b0;
        end else begin
            case (m_phase)
                0: if (start_i) begin m_phase = 1; m_w = 0; m_ovr = 1'b0; end
                1: if (px_valid_i) begin
                    m_wa_hold = m_w;
                    if (m_w == NPIX - 1) begin m_phase = 2; m_r = 0; end
                    else m_w++;
                end
                2: begin
                    if (px_valid_i) m_ovr = 1'b1;
                    if (out_ready_i) begin
                        m_ra_hold = crop_addr(m_r);
                        m_oi_hold = m_r;
                        if (m_r == NCROP - 1) m_phase = 3;
                        else m_r++;
                    end
                end
                default: begin
                    if (px_valid_i) m_ovr = 1'b1;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic compare_cycle();
        chk("px_ready", int'(px_ready_o), int'(m_phase == 1));
        chk("wr_inc", int'(wr_inc_o), int'(m_phase == 1 && px_valid_i));
        chk("rd_en", int'(rd_en_o), int'(m_phase == 2 && out_ready_i));
        chk("busy", int'(busy_o), int'(m_phase != 0));
        chk("frame_done", int'(frame_done_o), int'(m_phase == 3));
        if (m_phase == 1) chk("wr_addr", int'(wr_addr_o), m_w);
        if (m_phase == 0) begin
            chk("wr_addr_hold", int'(wr_addr_o), m_wa_hold);
            chk("rd_addr_hold", int'(rd_addr_o), m_ra_hold);
            chk("out_idx_hold", int'(out_idx_o), m_oi_hold);
        end
        if (m_phase == 2) begin
            chk("rd_addr", int'(rd_addr_o), crop_addr(m_r));
            chk("out_idx", int'(out_idx_o), m_r);
        end
`ifdef FRAME_SEQ_OVERRUN_EN
        chk("overrun", int'(overrun_o), int'(m_ovr));
`endif
        if (wr_inc_o) begin
            wr_cnt++;
            wr_log.push_back(int'(wr_addr_o));
        end
        if (rd_en_o) begin
            rd_log.push_back(int'(rd_addr_o));
            idx_log.push_back(int'(out_idx_o));
        end
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                model_update();
            end
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset state
        repeat (2) step();
        chk("reset_px_ready", int'(px_ready_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_rd_addr", int'(rd_addr_o), 0);
        chk("reset_out_idx", int'(out_idx_o), 0);
        reset_i = 1'b0;
        step();

        // 1+2: back-to-back fill, continuous readout
        clear_logs();
        out_ready_i = 1'b1;
        start_frame();
        fill_all();
        wait_done("t2");
        chk("t1_wr_count", wr_cnt, NPIX);
        chk("t1_wr_first", wr_log.size() > 0 ? wr_log[0] : -1, 0);
        chk("t1_wr_last", wr_log.size() == NPIX ? wr_log[NPIX-1] : -1, 47);
        check_read_logs("t2");
        $display("txn t2: frame of %0d writes, %0d reads", wr_cnt, rd_log.size());

        // 3: px_valid toggled during fill
        clear_logs();
        start_frame();
        for (int i = 0; i < 2 * NPIX; i++) begin
            px_valid_i = (i % 2 == 0);
            step();
        end
        px_valid_i = 1'b0;
        chk("t3_wr_count", wr_cnt, NPIX);
        chk("t3_in_read", int'(busy_o && !px_ready_o), 1);
        wait_done("t3");
        check_read_logs("t3");
        $display("txn t3: toggled fill, %0d writes", wr_cnt);

        // 4: out_ready low for 3 cycles at out_idx 5
        clear_logs();
        start_frame();
        fill_all();
        begin
            int n = 0;
            while (!(busy_o && !px_ready_o && out_idx_o == 8'd5) && n < 50) begin
                step();
                n++;
            end
        end
        chk("t4_reached_idx5", int'(out_idx_o), 5);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t4_stall_rd_en", int'(rd_en_o), 0);
            chk("t4_stall_rd_addr", int'(rd_addr_o), 19);
            step();
        end
        out_ready_i = 1'b1;
        wait_done("t4");
        check_read_logs("t4");
        $display("txn t4: stalled readout, %0d reads", rd_log.size());

        // 5: reset mid-read at rd_addr 20
        clear_logs();
        start_frame();
        fill_all();
        begin
            int n = 0;
            while (!(busy_o && !px_ready_o && rd_addr_o == 8'd20) && n < 50) begin
                step();
                n++;
            end
        end
        chk("t5_reached_20", int'(rd_addr_o), 20);
        reset_i = 1'b1;
        step();
        chk("t5_px_ready", int'(px_ready_o), 0);
        chk("t5_wr_inc", int'(wr_inc_o), 0);
        chk("t5_wr_addr", int'(wr_addr_o), 0);
        chk("t5_rd_en", int'(rd_en_o), 0);
        chk("t5_rd_addr", int'(rd_addr_o), 0);
        chk("t5_out_idx", int'(out_idx_o), 0);
        chk("t5_busy", int'(busy_o), 0);
        chk("t5_frame_done", int'(frame_done_o), 0);
        reset_i = 1'b0;
        repeat (3) begin
            step();
            chk("t5_no_done", int'(frame_done_o), 0);
        end
        $display("txn t5a: reset during read");

        // 5b: start pulses during fill and read are ignored
        clear_logs();
        start_frame();
        px_valid_i = 1'b1;
        repeat (20) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (NPIX - 21) step();
        px_valid_i = 1'b0;
        repeat (4) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done("t5b");
        chk("t5b_wr_count", wr_cnt, NPIX);
        check_read_logs("t5b");
        $display("txn t5b: start ignored while busy");

        // 6: pixels offered during read
        clear_logs();
        start_frame();
        px_valid_i = 1'b1;
        repeat (NPIX + 3) step();
        px_valid_i = 1'b0;
        wait_done("t6");
        chk("t6_wr_count", wr_cnt, NPIX);
        check_read_logs("t6");
`ifdef FRAME_SEQ_OVERRUN_EN
        chk("t6_overrun_set", int'(overrun_o), 1);
        step();
        chk("t6_overrun_sticky", int'(overrun_o), 1);
`endif
        start_frame();
`ifdef FRAME_SEQ_OVERRUN_EN
        chk("t6_overrun_cleared", int'(overrun_o), 0);
`endif
        fill_all();
        wait_done("t6b");
        $display("txn t6: pixels during read, %0d writes", wr_cnt);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
